// File: rtl/tile_pixel_stepper.sv
// tile_pixel_stepper: clears the tile Z buffer, then raster-scans each accepted polygon,
// stepping three edge functions and a Z plane per pixel into the Z buffer.
module tile_pixel_stepper #(
  parameter int TILE_LOG2 = 5
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     tile_start,
  input  logic                     tile_end,
  output logic                     tile_done,
  output logic                     clear_z,
  input  logic                     clear_done,
  input  logic                     poly_valid,
  output logic                     poly_ready,
  input  logic [95:0]              edge_a,
  input  logic [95:0]              edge_b,
  input  logic [95:0]              edge_c,
  input  logic [31:0]              z_c,
  input  logic [31:0]              z_dx,
  input  logic [31:0]              z_dy,
  input  logic [2:0]               poly_depth_comp,
  input  logic [2:0]               poly_type,
  input  logic                     poly_z_wr_dis,
  output logic                     pix_valid,
  output logic [2*TILE_LOG2-1:0]   z_buff_addr,
  output logic [31:0]              z_in,
  output logic                     inTriangle,
  output logic [2:0]               depth_comp,
  output logic [2:0]               type_cnt,
  output logic                     z_write_disable
);
  localparam logic [1:0] IDLE = 2'd0, CLEAR = 2'd1, WAIT_POLY = 2'd2, SCAN = 2'd3;
  logic [1:0] state;
  logic [95:0] a, b, e_row, e_pix;
  logic [31:0] dx, dy, z_row, z_pix;
  logic [TILE_LOG2-1:0] x, y;
  logic scan, accept;
  function automatic logic [95:0] add3(input logic [95:0] v, input logic [95:0] d);
    return {v[95:64] + d[95:64], v[63:32] + d[63:32], v[31:0] + d[31:0]};
  endfunction
  assign scan = state == SCAN;
  assign poly_ready = state == WAIT_POLY;
  assign accept = poly_ready && poly_valid;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      clear_z <= 1'b0;
      tile_done <= 1'b0;
      pix_valid <= 1'b0;
      z_buff_addr <= '0;
      z_in <= '0;
      inTriangle <= 1'b0;
      depth_comp <= '0;
      type_cnt <= '0;
      z_write_disable <= 1'b0;
      a <= '0;
      b <= '0;
      e_row <= '0;
      e_pix <= '0;
      dx <= '0;
      dy <= '0;
      z_row <= '0;
      z_pix <= '0;
      x <= '0;
      y <= '0;
    end else begin
      clear_z <= state == IDLE && tile_start;
      tile_done <= poly_ready && !poly_valid && tile_end;
      pix_valid <= scan;
      z_in <= scan ? z_pix : '0;
      inTriangle <= scan && !e_pix[31] && !e_pix[63] && !e_pix[95];
      if (scan) z_buff_addr <= {y, x};
      if (state == IDLE && tile_start) state <= CLEAR;
      if (state == CLEAR && clear_done) state <= WAIT_POLY;
      if (accept) begin
        a <= edge_a;
        b <= edge_b;
        dx <= z_dx;
        dy <= z_dy;
        e_row <= edge_c;
        e_pix <= edge_c;
        z_row <= z_c;
        z_pix <= z_c;
        x <= '0;
        y <= '0;
        depth_comp <= poly_depth_comp;
        type_cnt <= poly_type;
        z_write_disable <= poly_z_wr_dis;
        state <= SCAN;
      end else if (poly_ready && tile_end) state <= IDLE;
      if (scan) begin
        x <= x + 1'b1;
        // row wrap: both row and pixel accumulators read the old row start
        if (&x) begin
          e_row <= add3(e_row, b);
          e_pix <= add3(e_row, b);
          z_row <= z_row + dy;
          z_pix <= z_row + dy;
          y <= y + 1'b1;
          if (&y) state <= WAIT_POLY;
        end else begin
          e_pix <= add3(e_pix, a);
          z_pix <= z_pix + dx;
        end
      end
    end
endmodule

// File: tb/tb_tile_pixel_stepper.sv
// tb_tile_pixel_stepper: table-driven and random polygons checked against a closed-form plane model.
module tb_tile_pixel_stepper;
  logic clock = 0, reset_n = 0;
  logic tile_start = 0, tile_end = 0, clear_done = 0, poly_valid = 0;
  logic tile_done, clear_z, poly_ready, pix_valid, inTriangle, z_write_disable;
  logic [95:0] edge_a = '0, edge_b = '0, edge_c = '0;
  logic [31:0] z_c = '0, z_dx = '0, z_dy = '0, z_in;
  logic [2:0] poly_depth_comp = '0, poly_type = '0, depth_comp, type_cnt;
  logic poly_z_wr_dis = 0;
  logic [9:0] z_buff_addr;
  int errors = 0, checks = 0;

  typedef struct {
    logic [95:0] a, b, c;
    logic [31:0] zc, dx, dy;
    logic [2:0] dc, ty;
    logic wd;
    int exp_in;
    logic [31:0] exp_zlast;
  } vec_t;
  vec_t tbl[4];

  tile_pixel_stepper dut (
    .clock(clock), .reset_n(reset_n), .tile_start(tile_start), .tile_end(tile_end),
    .tile_done(tile_done), .clear_z(clear_z), .clear_done(clear_done),
    .poly_valid(poly_valid), .poly_ready(poly_ready), .edge_a(edge_a), .edge_b(edge_b),
    .edge_c(edge_c), .z_c(z_c), .z_dx(z_dx), .z_dy(z_dy), .poly_depth_comp(poly_depth_comp),
    .poly_type(poly_type), .poly_z_wr_dis(poly_z_wr_dis), .pix_valid(pix_valid),
    .z_buff_addr(z_buff_addr), .z_in(z_in), .inTriangle(inTriangle), .depth_comp(depth_comp),
    .type_cnt(type_cnt), .z_write_disable(z_write_disable));

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int a0, a1, a2, b0, b1, b2, c0, c1, c2,
                              input logic [31:0] zc, dx, dy, input logic [2:0] dc, ty,
                              input logic wd, input int ein, input logic [31:0] zl);
    vec_t v;
    v.a = {32'(a2), 32'(a1), 32'(a0)};
    v.b = {32'(b2), 32'(b1), 32'(b0)};
    v.c = {32'(c2), 32'(c1), 32'(c0)};
    v.zc = zc; v.dx = dx; v.dy = dy; v.dc = dc; v.ty = ty; v.wd = wd;
    v.exp_in = ein; v.exp_zlast = zl;
    return v;
  endfunction

  function automatic vec_t rnd_vec;
    vec_t v;
    for (int i = 0; i < 3; i++) begin
      v.a[32*i+:32] = 32'($urandom_range(0, 64)) - 32'd32;
      v.b[32*i+:32] = 32'($urandom_range(0, 64)) - 32'd32;
      v.c[32*i+:32] = 32'($urandom_range(0, 2000)) - 32'd600;
    end
    v.zc = $urandom; v.dx = $urandom; v.dy = $urandom;
    v.dc = 3'($urandom); v.ty = 3'($urandom_range(0, 4)); v.wd = 1'($urandom);
    v.exp_in = -1; v.exp_zlast = '0;
    return v;
  endfunction

  // closed-form plane evaluation: value = C + A*x + B*y (mod 2^32)
  function automatic logic [41:0] model(input vec_t v, input int px, input int py);
    logic [31:0] xx, yy, e, z;
    logic in = 1'b1;
    xx = 32'(px); yy = 32'(py);
    for (int i = 0; i < 3; i++) begin
      e = v.c[32*i+:32] + v.a[32*i+:32] * xx + v.b[32*i+:32] * yy;
      if (e[31]) in = 1'b0;
    end
    z = v.zc + v.dx * xx + v.dy * yy;
    return {in, z, 9'(0)};
  endfunction

  task automatic drive(input vec_t v);
    edge_a = v.a; edge_b = v.b; edge_c = v.c; z_c = v.zc; z_dx = v.dx; z_dy = v.dy;
    poly_depth_comp = v.dc; poly_type = v.ty; poly_z_wr_dis = v.wd;
  endtask

  task automatic send_poly(input vec_t v);
    for (int i = 0; i < 20 && !poly_ready; i++) tick;
    chk("poly_ready_before_send", poly_ready, 1);
    drive(v);
    poly_valid = 1;
    tick;
    poly_valid = 0;
  endtask

  task automatic start_tile(input logic te);
    tile_start = 1;
    tick;
    tile_start = 0;
    tile_end = te;
    chk("clear_z_pulse", {clear_z, poly_ready}, 2'b10);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("clear_wait", {clear_z, poly_ready, pix_valid, tile_done}, 0);
    end
    clear_done = 1;
    tick;
    clear_done = 0;
    tile_end = 0;
    chk("ready_after_clear", {poly_ready, clear_z}, 2'b10);
  endtask

  task automatic collect(input vec_t v, output int npix, output int nin, output logic [31:0] zl);
    logic [41:0] m;
    npix = 0; nin = 0; zl = '0;
    for (int i = 0; i < 8 && !pix_valid; i++) tick;
    chk("pix_valid_start", pix_valid, 1);
    for (int k = 0; k < 1024 && pix_valid; k++) begin
      m = model(v, k % 32, k / 32);
      chk($sformatf("pixel_%0d", k),
          {z_buff_addr, z_in, inTriangle, depth_comp, type_cnt, z_write_disable, tile_done},
          {10'(k), m[40:9], m[41], v.dc, v.ty, v.wd, 1'b0});
      npix++;
      if (inTriangle) nin++;
      zl = z_in;
      tick;
    end
    chk("pixel_count", npix, 1024);
    chk("idle_after_scan", {pix_valid, z_in, inTriangle}, 0);
  endtask

  initial begin
    vec_t v1, v2;
    int np, ni;
    logic [31:0] zl;
    tbl[0] = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 32'd100, 32'd1, 32'd32, 3'd1, 3'd0, 1'b0, 1024, 32'd1123);
    tbl[1] = mk(-1, 0, 0, 0, 0, 0, 15, 1, 1, 32'd0, 32'd0, 32'd0, 3'd2, 3'd1, 1'b1, 512, 32'd0);
    tbl[2] = mk(0, 0, 0, 0, 0, 0, -1, -1, -1, 32'hFFFF_FFFB, 32'd2, 32'hFFFF_FFFF, 3'd7, 3'd4, 1'b0, 0, 32'd26);
    tbl[3] = mk(0, 0, 0, -1, 0, 0, 10, 0, 0, 32'hFFFF_FFF0, 32'd1, 32'd0, 3'd5, 3'd3, 1'b1, 352, 32'h0000_000F);
    tick; tick;
    chk("reset_outputs", {pix_valid, clear_z, tile_done, poly_ready, inTriangle, z_in, z_buff_addr,
                          depth_comp, type_cnt, z_write_disable}, 0);
    reset_n = 1;
    tick;
    chk("idle_no_ready", {poly_ready, clear_z}, 0);
    start_tile(1'b1);
    for (int t = 0; t < 4; t++) begin
      send_poly(tbl[t]);
      collect(tbl[t], np, ni, zl);
      if (tbl[t].exp_in >= 0) begin
        chk($sformatf("inside_count_%0d", t), ni, tbl[t].exp_in);
        chk($sformatf("z_last_%0d", t), zl, tbl[t].exp_zlast);
      end
    end
    for (int r = 0; r < 2; r++) begin
      v1 = rnd_vec();
      send_poly(v1);
      collect(v1, np, ni, zl);
    end
    // back-to-back with poly_valid held high
    v1 = rnd_vec(); v2 = rnd_vec();
    v1.dc = 3'd1; v1.ty = 3'd2; v2.dc = 3'd6; v2.ty = 3'd4;
    drive(v1);
    poly_valid = 1;
    tick;
    drive(v2);
    collect(v1, np, ni, zl);
    chk("b2b_ctl_switch", {depth_comp, type_cnt, z_write_disable}, {v2.dc, v2.ty, v2.wd});
    poly_valid = 0;
    collect(v2, np, ni, zl);
    // poly_valid beats tile_end; tile_end then closes the tile
    drive(tbl[0]);
    poly_valid = 1; tile_end = 1;
    tick;
    poly_valid = 0;
    chk("no_done_on_accept", {tile_done, poly_ready}, 0);
    collect(tbl[0], np, ni, zl);
    chk("tile_done_pulse", {tile_done, poly_ready}, 2'b10);
    tick;
    tile_end = 0;
    chk("tile_done_once", {tile_done, poly_ready}, 0);
    // reset in the middle of a scan
    start_tile(1'b0);
    send_poly(tbl[1]);
    for (int i = 0; i < 8 && !pix_valid; i++) tick;
    for (int i = 0; i < 500; i++) tick;
    chk("addr_at_500", {pix_valid, z_buff_addr}, {1'b1, 10'd500});
    reset_n = 0;
    #1;
    chk("async_reset", {pix_valid, z_buff_addr, z_in, inTriangle, poly_ready, depth_comp, type_cnt,
                        z_write_disable}, 0);
    tick;
    reset_n = 1;
    tick;
    chk("post_reset_quiet", {pix_valid, poly_ready, clear_z}, 0);
    start_tile(1'b0);
    send_poly(tbl[0]);
    collect(tbl[0], np, ni, zl);
    chk("restart_inside", ni, 1024);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
